// File: rtl/fft_frame_sequencer.sv
// Frame sequencer wrapped around an external 8-point FFT core.
// Collects 8 complex samples into a frame buffer and presents them to the core. It then waits
// out the core pipeline, captures all 8 bins, and streams them out one per handshake.
//
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   flush                 synchronous abort back to LOAD (wins over any handshake)
//   in_valid/in_ready     sample handshake; in_re/in_im carry the unsigned sample
//   core_x_re/core_x_im   packed frame to the core (sample k in slice k)
//   core_a_re/core_a_im   packed bins from the core (bin k in slice k, natural order)
//   out_valid/out_ready   bin handshake; out_re/out_im/out_idx/out_last describe the bin
//   busy                  high while a frame is in flight (RUN or DRAIN)
module fft_frame_sequencer #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_re,
  input  logic [IN_W-1:0]    in_im,
  output logic [8*IN_W-1:0]  core_x_re,
  output logic [8*IN_W-1:0]  core_x_im,
  input  logic [8*OUT_W-1:0] core_a_re,
  input  logic [8*OUT_W-1:0] core_a_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_re,
  output logic [OUT_W-1:0]   out_im,
  output logic [2:0]         out_idx,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned WaitW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(LATENCY);

  typedef enum logic [1:0] {StLoad, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [2:0]       wr_cnt_q, wr_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]       rd_idx_q, rd_idx_d;

  logic [IN_W-1:0]  frame_re_q [8];
  logic [IN_W-1:0]  frame_im_q [8];
  logic [IN_W-1:0]  frame_re_d [8];
  logic [IN_W-1:0]  frame_im_d [8];
  logic [OUT_W-1:0] res_re_q   [8];
  logic [OUT_W-1:0] res_im_q   [8];
  logic [OUT_W-1:0] res_re_d   [8];
  logic [OUT_W-1:0] res_im_d   [8];

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rd_idx_d   = rd_idx_q;
    frame_re_d = frame_re_q;
    frame_im_d = frame_im_q;
    res_re_d   = res_re_q;
    res_im_d   = res_im_q;

    if (flush) begin
      // Buffers are left as they are; only the sequencing state is cleared.
      state_d    = StLoad;
      wr_cnt_d   = 3'd0;
      wait_cnt_d = '0;
      rd_idx_d   = 3'd0;
    end else begin
      case (state_q)
        StLoad: begin
          if (in_valid) begin
            frame_re_d[wr_cnt_q] = in_re;
            frame_im_d[wr_cnt_q] = in_im;
            wr_cnt_d             = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
              state_d    = StRun;
              wait_cnt_d = '0;
            end
          end
        end
        StRun: begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
          // Core output reflects the new frame once LATENCY edges have passed.
          if (wait_cnt_q == WaitLast) begin
            for (int k = 0; k < 8; k++) begin
              res_re_d[k] = core_a_re[OUT_W*k +: OUT_W];
              res_im_d[k] = core_a_im[OUT_W*k +: OUT_W];
            end
            rd_idx_d = 3'd0;
            state_d  = StDrain;
          end
        end
        StDrain: begin
          if (out_ready) begin
            rd_idx_d = rd_idx_q + 3'd1;
            if (rd_idx_q == 3'd7) begin
              state_d = StLoad;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StLoad;
      wr_cnt_q   <= 3'd0;
      wait_cnt_q <= '0;
      rd_idx_q   <= 3'd0;
      for (int k = 0; k < 8; k++) begin
        frame_re_q[k] <= '0;
        frame_im_q[k] <= '0;
        res_re_q[k]   <= '0;
        res_im_q[k]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rd_idx_q   <= rd_idx_d;
      frame_re_q <= frame_re_d;
      frame_im_q <= frame_im_d;
      res_re_q   <= res_re_d;
      res_im_q   <= res_im_d;
    end
  end

  always_comb begin
    core_x_re = '0;
    core_x_im = '0;
    for (int k = 0; k < 8; k++) begin
      core_x_re[IN_W*k +: IN_W] = frame_re_q[k];
      core_x_im[IN_W*k +: IN_W] = frame_im_q[k];
    end
  end

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q != StLoad);
  assign out_idx   = rd_idx_q;
  assign out_last  = out_valid && (rd_idx_q == 3'd7);
  assign out_re    = res_re_q[rd_idx_q];
  assign out_im    = res_im_q[rd_idx_q];

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: models a LATENCY-stage 8-point DFT core around the DUT,
// drives frames from a vector table, and scoreboards the drained bins.
module tb_fft_frame_sequencer;

  localparam int unsigned LAT   = 3;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 12;
  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [IN_W-1:0]    in_re = '0;
  logic [IN_W-1:0]    in_im = '0;
  logic [8*IN_W-1:0]  core_x_re, core_x_im;
  logic [8*OUT_W-1:0] core_a_re, core_a_im;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [OUT_W-1:0]   out_re, out_im;
  logic [2:0]         out_idx;
  logic               out_last, busy;

  fft_frame_sequencer #(.LATENCY(LAT), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .core_x_re(core_x_re), .core_x_im(core_x_im),
    .core_a_re(core_a_re), .core_a_im(core_a_im), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference DFT and core model ----------------
  function automatic logic [OUT_W-1:0] dft_bin(input int k, input bit want_im,
                                                input int xr[8], input int xi[8]);
    real acc;
    real th;
    int  r;
    acc = 0.0;
    for (int n = 0; n < 8; n++) begin
      th = 2.0 * PI * real'(k * n) / 8.0;
      if (!want_im) acc = acc + real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
      else          acc = acc + real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
    end
    r = (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(-acc + 0.5);
    return OUT_W'(r);
  endfunction

  int cxr[8], cxi[8];
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      cxr[n] = int'(core_x_re[IN_W*n +: IN_W]);
      cxi[n] = int'(core_x_im[IN_W*n +: IN_W]);
    end
  end

  logic [OUT_W-1:0] pipe_re [LAT][8];
  logic [OUT_W-1:0] pipe_im [LAT][8];
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      pipe_re[0][k] <= dft_bin(k, 1'b0, cxr, cxi);
      pipe_im[0][k] <= dft_bin(k, 1'b1, cxr, cxi);
      for (int s = 1; s < LAT; s++) begin
        pipe_re[s][k] <= pipe_re[s-1][k];
        pipe_im[s][k] <= pipe_im[s-1][k];
      end
    end
  end
  always_comb begin
    core_a_re = '0;
    core_a_im = '0;
    for (int k = 0; k < 8; k++) begin
      core_a_re[OUT_W*k +: OUT_W] = pipe_re[LAT-1][k];
      core_a_im[OUT_W*k +: OUT_W] = pipe_im[LAT-1][k];
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct packed {
    logic [7:0][IN_W-1:0]  re;
    logic [7:0][IN_W-1:0]  im;
    logic [7:0][OUT_W-1:0] exp_re;
    logic [7:0][OUT_W-1:0] exp_im;
    logic                  gaps;
    logic                  bp;
  } vec_t;

  typedef struct {
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
    logic [2:0]       idx;
  } bin_t;

  vec_t tbl[6];
  bin_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   acc_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send_frame(input vec_t v);
    int w;
    for (int n = 0; n < 8; n++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      in_re    = v.re[n];
      in_im    = v.im[n];
      w = 0;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    acc_cyc  = cyc;
    chk("core_x_re", 64'(core_x_re), 64'(v.re));
    chk("core_x_im", 64'(core_x_im), 64'(v.im));
    chk("in_ready_after_8th", 64'(in_ready), 64'd0);
    chk("busy_after_8th", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      sbq.push_back('{re: v.exp_re[k], im: v.exp_im[k], idx: 3'(k)});
    end
  endtask

  // Pops n_pop bins; garbage is offered on the input side to show it is ignored.
  task automatic drain(input vec_t v, input int n_pop);
    int w;
    int popped;
    int step;
    bin_t h;
    w = 0;
    popped = 0;
    step = 0;
    in_valid = 1'b1;
    in_re    = 8'hA5;
    in_im    = 8'h5A;
    while (!out_valid && w < 20) begin
      chk("in_ready_run", 64'(in_ready), 64'd0);
      tick();
      w++;
    end
    chk("first_valid_latency", 64'(cyc - acc_cyc), 64'(LAT + 1));
    while (popped < n_pop && step < 100) begin
      out_ready = v.bp ? (step % 3 == 0) : 1'b1;
      if (!out_valid || sbq.size() == 0) begin
        chk("drain_valid", 64'(out_valid), 64'd1);
        chk("drain_sbq_empty", 64'(sbq.size()), 64'd1);
        break;
      end
      h = sbq[0];
      chk("out_re", 64'(out_re), 64'(h.re));
      chk("out_im", 64'(out_im), 64'(h.im));
      chk("out_idx", 64'(out_idx), 64'(h.idx));
      chk("out_last", 64'(out_last), 64'(h.idx == 3'd7));
      chk("in_ready_drain", 64'(in_ready), 64'd0);
      chk("busy_drain", 64'(busy), 64'd1);
      chk("frame_held", 64'(core_x_re), 64'(v.re));
      if (out_ready) begin
        void'(sbq.pop_front());
        popped++;
      end
      tick();
      step++;
    end
    in_valid = 1'b0;
    if (n_pop == 8) begin
      chk("in_ready_after_last", 64'(in_ready), 64'd1);
      chk("out_valid_after_last", 64'(out_valid), 64'd0);
      chk("busy_after_last", 64'(busy), 64'd0);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xr[8], xi[8];

    // Impulse, DC, random (plain / with gaps), random with backpressure, impulse with backpressure
    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].re[0] = 8'd1;
    for (int k = 0; k < 8; k++) tbl[0].exp_re[k] = 12'd1;
    for (int n = 0; n < 8; n++) tbl[1].re[n] = 8'd10;
    tbl[1].exp_re[0] = 12'd80;
    for (int n = 0; n < 8; n++) begin
      tbl[2].re[n] = 8'($urandom_range(0, 127));
      tbl[2].im[n] = 8'($urandom_range(0, 127));
      tbl[4].re[n] = 8'($urandom_range(0, 127));
      tbl[4].im[n] = 8'($urandom_range(0, 127));
    end
    for (int i = 2; i <= 4; i += 2) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = int'(tbl[i].re[n]);
        xi[n] = int'(tbl[i].im[n]);
      end
      for (int k = 0; k < 8; k++) begin
        tbl[i].exp_re[k] = dft_bin(k, 1'b0, xr, xi);
        tbl[i].exp_im[k] = dft_bin(k, 1'b1, xr, xi);
      end
    end
    tbl[3]      = tbl[2];
    tbl[3].gaps = 1'b1;
    tbl[4].bp   = 1'b1;
    tbl[5]      = tbl[0];
    tbl[5].bp   = 1'b1;

    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_re", 64'(out_re), 64'd0);
    chk("rst_out_im", 64'(out_im), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_core_x", 64'(core_x_re | core_x_im), 64'd0);
    #10 rst = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i]);
      drain(tbl[i], 8);
    end

    // Flush after 5 samples, coincident with a valid 6th sample
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      in_re    = 8'd50;
      in_im    = 8'd7;
      tick();
    end
    in_re = 8'd99;
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_load_in_ready", 64'(in_ready), 64'd1);
    chk("flush_load_busy", 64'(busy), 64'd0);
    send_frame(tbl[0]);
    drain(tbl[0], 8);

    // Flush during DRAIN coincident with an output handshake
    send_frame(tbl[2]);
    drain(tbl[2], 2);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drain_out_valid", 64'(out_valid), 64'd0);
    chk("flush_drain_in_ready", 64'(in_ready), 64'd1);
    chk("flush_drain_idx", 64'(out_idx), 64'd0);
    sbq.delete();
    send_frame(tbl[1]);
    drain(tbl[1], 8);

    // Reset mid-DRAIN at idx 3 takes effect without a clock edge
    send_frame(tbl[4]);
    drain(tbl[4], 3);
    out_ready = 1'b0;
    chk("pre_rst_idx", 64'(out_idx), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_idx", 64'(out_idx), 64'd0);
    chk("async_rst_out_re", 64'(out_re), 64'd0);
    #3 rst = 1'b1;
    tick();
    tick();
    sbq.delete();
    out_ready = 1'b1;
    send_frame(tbl[2]);
    drain(tbl[2], 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter LATENCY, default 3: register stages in the attached 8-point FFT core, from input sample change to valid bin outputs.
REQ-002 Parameter IN_W, default 8: unsigned sample component width.
REQ-003 Parameter OUT_W, default 12: signed bin component width.
REQ-004 clk  input  1  single clock for the sequencer and the FFT core.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous abort; returns the block to LOAD.
REQ-007 in_valid  input  1  sample offered.
REQ-008 in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-009 in_re, in_im  input  IN_W each  unsigned sample components.
REQ-010 core_x_re, core_x_im  output  8*IN_W each  frame to core; sample k at bits [IN_W*k+IN_W-1 : IN_W*k].
REQ-011 core_a_re, core_a_im  input  8*OUT_W each  core bins; bin k at bits [OUT_W*k+OUT_W-1 : OUT_W*k], natural order.
REQ-012 out_valid  output  1  result bin presented.
REQ-013 out_ready  input  1  bin consumed when out_valid && out_ready.
REQ-014 out_re, out_im  output  OUT_W each  signed bin value.
REQ-015 out_idx  output  3  bin index of the presented value.
REQ-016 out_last  output  1  high with out_valid when out_idx == 7.
REQ-017 busy  output  1  high in RUN and DRAIN.

Function
REQ-018 The state machine SHALL have three states: LOAD, RUN and DRAIN.
REQ-019 In LOAD, in_ready SHALL be 1; each accepted sample SHALL be written to frame buffer slot wr_cnt, then wr_cnt SHALL increment.
REQ-020 On the acceptance of slot 7, the state SHALL go to RUN, wr_cnt SHALL wrap to 0, and wait_cnt SHALL clear to 0.
REQ-021 core_x_re/core_x_im SHALL be driven combinationally from the frame buffer at all times.
REQ-022 The frame buffer SHALL NOT change in RUN or DRAIN.
REQ-023 In RUN, wait_cnt SHALL increment each cycle.
REQ-024 At the clock edge ending the RUN cycle with wait_cnt == LATENCY, all 16 core bin components SHALL be captured into the result buffer, rd_idx SHALL clear to 0, and the state SHALL go to DRAIN.
REQ-025 RUN SHALL therefore last LATENCY+1 cycles, and out_valid SHALL first rise LATENCY+1 cycles after the edge that accepted slot 7.
REQ-026 In DRAIN, out_valid SHALL be 1, out_idx SHALL equal rd_idx, and out_re/out_im SHALL equal result buffer entry rd_idx.
REQ-027 In DRAIN, outputs SHALL be held stable while out_ready is 0.
REQ-028 On each DRAIN handshake, rd_idx SHALL increment.
REQ-029 The handshake with out_last = 1 SHALL return the state to LOAD, with in_ready = 1 on the next cycle.
REQ-030 in_ready SHALL be 0 in RUN and DRAIN; out_valid SHALL be 0 in LOAD and RUN.
REQ-031 When flush = 1 in any state, the next state SHALL be LOAD with wr_cnt, wait_cnt and rd_idx cleared, and the result buffer contents SHALL be abandoned.
REQ-032 flush SHALL take priority over a simultaneous input or output handshake; that sample or bin SHALL be discarded or not counted.
REQ-033 Frame buffer and result buffer contents SHALL persist across flush and are not guaranteed meaningful afterwards.
REQ-034 No arithmetic SHALL be performed on data: samples and bins pass bit-exact, without width change.
REQ-035 Throughput SHALL be at most one frame per 8 + (LATENCY+1) + 8 cycles, with no overlap between load and drain.

Reset
REQ-036 While rst = 0: state = LOAD, wr_cnt = 0, wait_cnt = 0, rd_idx = 0, in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_re = out_im = 0, out_idx = 0, all buffers = 0.
REQ-037 Reset assertion SHALL take effect immediately, in any state including mid-RUN or mid-DRAIN; release SHALL be synchronised so that the first state change occurs on a clock edge.

Verification
REQ-038 Impulse (LATENCY = 3, out_ready = 1): x0 = (1,0), x1..x7 = (0,0) -> out_valid rises 4 cycles after the 8th accept; 8 consecutive bins, each (1,0), idx 0..7, out_last on idx 7.
REQ-039 DC: all samples = (10,0) -> bin0 = (80,0), bin4 = (0,0); busy high from the 8th accept until the idx-7 handshake.
REQ-040 Backpressure: out_ready toggles 1,0,0,1,... -> no bin repeated or skipped; values held while stalled; in_ready stays 0 until after the out_last handshake.
REQ-041 in_valid gaps: 8 samples with random idle cycles -> identical core_x contents and results to the gap-free case.
REQ-042 flush after 5 samples, coincident with a valid sample -> that sample is dropped; the next 8 accepted samples form a clean frame with correct impulse result.
REQ-043 rst = 0 asserted mid-DRAIN at idx 3 -> out_valid = 0 immediately; after release, in_ready = 1 and a full new frame is processed correctly.
